lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: WAIT-state cycles before timeout.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid in 1 / in_ready out 1: upstream (ex-side) handshake.
REQ-005 SHALL have ports in_is_load in 1, in_is_store in 1, in_funct3 in 3, in_addr in 32, in_wdata in 32, in_rd in 5: request payload.
REQ-006 SHALL have ports out_valid out 1 / out_ready in 1: downstream (wb-side) handshake.
REQ-007 SHALL have ports out_rdata out 32, out_rd out 5, out_err out 1: response payload.
REQ-008 SHALL have ports mem_req out 1, mem_wen out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_wmask out 4, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32: memory port.

Function
REQ-009 SHALL use an FSM with states IDLE, REQ, WAIT, RESP; in_ready=1 only in IDLE.
REQ-010 SHALL capture the payload on in_valid&in_ready; move to REQ if load/store is legal, else to RESP.
REQ-011 SHALL hold mem_req=1 with stable address/data/mask in REQ until mem_gnt=1, then go to WAIT.
REQ-012 SHALL sample mem_rvalid only in WAIT; rvalid in any other state SHALL be ignored (stores also wait for rvalid as ack).
REQ-013 SHALL on rvalid in WAIT go to RESP; minimum latency: accept at T, mem_req at T+1, gnt at T+1, rvalid at T+2, out_valid at T+3.
REQ-014 SHALL count WAIT cycles; when the count reaches MAX_WAIT without rvalid, go to RESP with out_err=1 and out_rdata=0.
REQ-015 SHALL hold out_valid=1 and stable payload in RESP until out_ready=1, then return to IDLE (no same-cycle accept).
REQ-016 SHALL treat in_valid with neither load nor store as passthrough: RESP, out_rdata=0, out_err=0, no memory access.
REQ-017 SHALL for loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend.
REQ-018 SHALL for stores: 000 SB mask 0001<<off with byte replicated ×4; 001 SH mask 0011<<off with half replicated ×2; 010 SW mask 1111.
REQ-019 SHALL flag funct3 011/110/111 (and 100/101 on stores) as illegal: RESP, out_err=1, no memory access.
REQ-020 SHALL drive mem_wen=1 for stores, 0 for loads, and mem_addr={addr[31:2],2'b00}.

Reset
REQ-021 SHALL on rst=1 go to IDLE and clear the wait counter; out_valid, out_err, mem_req, mem_wen=0; out_rdata, mem_addr, mem_wdata=0; mem_wmask=0000; out_rd=0.
REQ-022 SHALL abandon any in-flight access when rst is asserted mid-operation; a later rvalid SHALL be ignored.

Configuration
REQ-023 SHALL, with LSU_MISALIGN_TRAP_EN defined, send misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) to RESP with out_err=1 and no memory access.
REQ-024 SHALL, without LSU_MISALIGN_TRAP_EN, force the offset to be size-aligned (clear addr[0] for halfword, addr[1:0] for word) and perform the access normally.

Structure
REQ-025 SHALL take the FSM state enum and the load/store funct3 constants from the shared package xcore_pkg.
REQ-026 SHALL place load extraction/extension and store mask/replication in one combinational sub-module, lsu_align.

Verification
REQ-027 SHALL cover: LB addr 0x1003, mem_rdata 0x80FF_FFFF, gnt and rvalid immediate -> out_valid at T+3, out_rdata 0xFFFF_FF80.
REQ-028 SHALL cover: SH addr 0x2002, wdata 0x0000_ABCD -> mem_wmask 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x2000, mem_wen=1.
REQ-029 SHALL cover: mem_gnt held low for 5 cycles -> mem_req and payload stable for all 5; WAIT entered on the gnt cycle.
REQ-030 SHALL cover: MAX_WAIT=4, no rvalid -> out_err=1, out_rdata=0 after 4 WAIT cycles; a late rvalid in IDLE is ignored.
REQ-031 SHALL cover: LW addr 0x1002 -> with the macro, out_err=1 and mem_req never asserted; without it, mem_addr 0x1000 and the word is returned.
REQ-032 SHALL cover: out_ready low for 3 cycles, then rst -> out_valid stable during the stall; next cycle IDLE, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/xcore_pkg.sv
// Shared core definitions: LSU FSM states, load/store funct3 encodings and
// offset helpers used by the load/store unit.
package xcore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Drops the low offset bits that a halfword/word access cannot use.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        if (f3_is_half(f3))
            return {off[1], 1'b0};
        else if (f3 == F3_W)
            return 2'b00;
        else
            return off;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3_is_half(f3))
            return off[0];
        else if (f3 == F3_W)
            return off != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: load extraction with sign/zero extension
// and store byte-mask generation with data replication. Purely combinational.
module lsu_align
    import xcore_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        o_rdata = '0;
        o_wmask = '0;
        o_wdata = '0;
        case (i_funct3)
            F3_B: begin
                o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
                o_wmask = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
                o_wmask = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            F3_W: begin
                o_rdata = w_shift;
                o_wmask = 4'b1111;
                o_wdata = i_wdata;
            end
            F3_BU: o_rdata = {24'h0, w_shift[7:0]};
            F3_HU: o_rdata = {16'h0, w_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between EX and WB.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// instead of silently aligning them.
module lsu_ctrl
    import xcore_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    lsu_state_e    r_state, w_next;
    logic [CW-1:0] r_wait_cnt;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic [4:0]    r_rd;
    logic          r_wen, r_err;

    logic          w_accept, w_ld_ok, w_st_ok, w_misalign, w_mem, w_illegal, w_timeout;
    logic [3:0]    w_wmask;
    logic [31:0]   w_wdata_rep, w_rdata_ext;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_ld_ok  = in_is_load && (in_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_st_ok  = in_is_store && !in_is_load && (in_funct3 inside {F3_B, F3_H, F3_W});
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(in_funct3, in_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_mem     = (w_ld_ok || w_st_ok) && !w_misalign;
    assign w_illegal = (in_is_load || in_is_store) && !w_mem;
    assign w_timeout = (r_wait_cnt == WAIT_LAST) && !mem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_mem ? ST_REQ : ST_RESP;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) w_next = ST_WAIT;
            end
            ST_WAIT: if (mem_rvalid || w_timeout) w_next = ST_RESP;
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_rd       <= '0;
            r_wen      <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= {in_addr[31:2], 2'b00};
                r_off      <= align_off(in_funct3, in_addr[1:0]);
                r_funct3   <= in_funct3;
                r_wdata    <= in_wdata;
                r_rd       <= in_rd;
                r_wen      <= w_mem && w_st_ok;
                r_rdata    <= '0;
                r_err      <= w_illegal;
                r_wait_cnt <= '0;
            end
            // Stores also complete on rvalid; their response carries no data.
            if (r_state == ST_WAIT) begin
                if (mem_rvalid) begin
                    r_rdata <= r_wen ? 32'h0 : w_rdata_ext;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
        end
    end

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata),
        .o_wmask  (w_wmask),
        .o_wdata  (w_wdata_rep),
        .o_rdata  (w_rdata_ext)
    );

    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wmask = r_wen ? w_wmask : 4'b0000;
    assign mem_wdata = r_wen ? w_wdata_rep : 32'h0;
    assign out_rdata = r_rdata;
    assign out_err   = r_err;
    assign out_rd    = r_rd;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario bench for lsu_ctrl: expected responses are queued at issue time
// and compared when out_valid appears; memory side is driven per scenario.
module tb_lsu_ctrl;
    import xcore_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_rd(out_rd), .out_err(out_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            F3_W:    return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, queues its expected response, returns one cycle after acceptance.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        e.rdata = exp_rdata; e.err = exp_err; e.rd = rd;
        sb.push_back(e);
        tick();
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_err, mem_req, mem_wen, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctl: got v/err/req/wen/rdy=%b want 00001",
                     {out_valid, out_err, mem_req, mem_wen, in_ready});
        end
        n_tests++;
        if ({out_rdata, out_rd, mem_addr, mem_wdata, mem_wmask} !== 105'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h rd=%0d addr=%h wdata=%h mask=%b want all zero",
                     out_rdata, out_rd, mem_addr, mem_wdata, mem_wmask);
        end
    endtask

    task automatic test_lb;
        exp_t e;
        issue(1'b1, 1'b0, F3_B, 32'h0000_1003, 32'h0, 5'd5, 32'hFFFF_FF80, 1'b0);
        mem_gnt = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || mem_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_req: got req=%b addr=%h wen=%b want 1 00001000 0", mem_req, mem_addr, mem_wen);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_early: got out_valid=%b at T+2 want 0", out_valid);
        end
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_latency: got out_valid=%b at T+3 want 1", out_valid);
        end
        e = sb.pop_front();
        n_tests++;
        if ({out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL lb_resp: got %h/%b/%0d want %h/%b/%0d", out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
        end
        release_out();
    endtask

    task automatic test_sh;
        exp_t e;
        bit   ok;
        issue(1'b0, 1'b1, F3_H, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({mem_req, mem_wen, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_ABCD}) begin
            n_fail++;
            $display("FAIL sh_req: got req=%b wen=%b mask=%b addr=%h wdata=%h want 1 1 1100 00002000 abcdabcd",
                     mem_req, mem_wen, mem_wmask, mem_addr, mem_wdata);
        end
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        wait_out(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sh_done: got no out_valid within bound want out_valid=1");
        end
        e = sb.pop_front();
        n_tests++;
        if ({out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL sh_resp: got %h/%b/%0d want %h/%b/%0d", out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
        end
        release_out();
    endtask

    task automatic test_gnt_stall;
        exp_t e;
        bit   ok;
        issue(1'b1, 1'b0, F3_H, 32'h0000_3002, 32'h0, 5'd7, 32'hFFFF_8001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_wen !== 1'b0 || mem_wmask !== 4'b0) begin
                n_fail++;
                $display("FAIL gnt_stall[%0d]: got req=%b addr=%h wen=%b mask=%b want 1 00003000 0 0000",
                         i, mem_req, mem_addr, mem_wen, mem_wmask);
            end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: got req=%b out_valid=%b want 0 0", mem_req, out_valid);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        wait_out(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL lh_resp: got valid=%b %h/%b/%0d want 1 %h/%b/%0d",
                     ok, out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
        end
        release_out();
    endtask

    task automatic test_timeout;
        exp_t e;
        issue(1'b1, 1'b0, F3_W, 32'h0000_4000, 32'h0, 5'd9, 32'h0, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early[%0d]: got out_valid=%b want 0", i, out_valid);
            end
            tick();
        end
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (out_valid !== 1'b1 || {out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL timeout_resp: got valid=%b %h/%b/%0d want 1 %h/%b/%0d",
                     out_valid, out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
        end
        release_out();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL late_rvalid: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_misalign;
        exp_t e;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, F3_W, 32'h0000_1002, 32'h0, 5'd10, 32'h0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_trap: got req=%b out_valid=%b want 0 1", mem_req, out_valid);
        end
`else
        bit ok;
        issue(1'b1, 1'b0, F3_W, 32'h0000_1002, 32'h0, 5'd10, 32'hCAFE_F00D, 1'b0);
        mem_gnt = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL lw_align: got req=%b addr=%h want 1 00001000", mem_req, mem_addr);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        wait_out(ok);
`endif
        e = sb.pop_front();
        n_tests++;
        if ({out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
            n_fail++;
            $display("FAIL lw_misalign_resp: got %h/%b/%0d want %h/%b/%0d",
                     out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
        end
        release_out();
    endtask

    task automatic test_nomem;
        exp_t       e;
        logic       lds[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       sts[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] f3s[4]  = '{3'b000, 3'b011, 3'b100, 3'b110};
        logic       errs[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(lds[i], sts[i], f3s[i], 32'h5000 + i, 32'hFFFF_FFFF, 5'(12 + i), 32'h0, errs[i]);
            @(negedge clk);
            n_tests++;
            if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL nomem[%0d]: got req=%b out_valid=%b want 0 1", i, mem_req, out_valid);
            end
            e = sb.pop_front();
            n_tests++;
            if ({out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
                n_fail++;
                $display("FAIL nomem_resp[%0d]: got %h/%b/%0d want %h/%b/%0d",
                         i, out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        logic [2:0]  ldf[5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        logic [2:0]  stf[3] = '{F3_B, F3_H, F3_W};
        logic [2:0]  f3;
        logic [31:0] a, w, d, xd;
        logic [3:0]  xm;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom(); w = $urandom(); d = $urandom();
            if (i % 2 == 0) begin
                f3 = ldf[$urandom_range(0, 4)];
                if (f3_is_half(f3)) a[0] = 1'b0;
                if (f3 == F3_W) a[1:0] = 2'b00;
                issue(1'b1, 1'b0, f3, a, d, 5'(i + 1), ld_model(f3, a[1:0], w), 1'b0);
            end else begin
                f3 = stf[$urandom_range(0, 2)];
                if (f3 == F3_H) a[0] = 1'b0;
                if (f3 == F3_W) a[1:0] = 2'b00;
                case (f3)
                    F3_B:    begin xm = 4'b0001 << a[1:0]; xd = {4{d[7:0]}}; end
                    F3_H:    begin xm = a[1] ? 4'b1100 : 4'b0011; xd = {2{d[15:0]}}; end
                    default: begin xm = 4'b1111; xd = d; end
                endcase
                issue(1'b0, 1'b1, f3, a, d, 5'(i + 1), 32'h0, 1'b0);
            end
            @(negedge clk);
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_wen !== (i % 2 == 1) ||
                ((i % 2 == 1) && (mem_wmask !== xm || mem_wdata !== xd))) begin
                n_fail++;
                $display("FAIL b2b_req[%0d]: got req=%b addr=%h wen=%b mask=%b wdata=%h want 1 %h %b %b %h",
                         i, mem_req, mem_addr, mem_wen, mem_wmask, mem_wdata,
                         {a[31:2], 2'b00}, (i % 2 == 1), xm, xd);
            end
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = w;
            tick();
            mem_rvalid = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if (out_valid !== 1'b1 || {out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
                n_fail++;
                $display("FAIL b2b_resp[%0d]: got valid=%b %h/%b/%0d want 1 %h/%b/%0d",
                         i, out_valid, out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort;
        issue(1'b1, 1'b0, F3_W, 32'h0000_6000, 32'h0, 5'd4, 32'h0, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got out_valid=%b in_ready=%b req=%b want 0 1 0", out_valid, in_ready, mem_req);
        end
    endtask

    task automatic test_resp_stall_reset;
        exp_t e;
        issue(1'b0, 1'b0, F3_W, 32'h7777_0004, 32'h1111_2222, 5'd3, 32'h0, 1'b0);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || {out_rdata, out_err, out_rd} !== {e.rdata, e.err, e.rd}) begin
                n_fail++;
                $display("FAIL resp_stall[%0d]: got valid=%b %h/%b/%0d want 1 %h/%b/%0d",
                         i, out_valid, out_rdata, out_err, out_rd, e.rdata, e.err, e.rd);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_err, mem_req, mem_wen, in_ready} !== 5'b00001 ||
            {out_rdata, out_rd, mem_addr, mem_wdata, mem_wmask} !== 105'h0) begin
            n_fail++;
            $display("FAIL stall_reset: got v/err/req/wen/rdy=%b addr=%h rd=%0d want 00001 addr 0 rd 0",
                     {out_valid, out_err, mem_req, mem_wen, in_ready}, mem_addr, out_rd);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'b0; in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0;
        out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_lb();
        test_sh();
        test_gnt_stall();
        test_timeout();
        test_misalign();
        test_nomem();
        test_back_to_back();
        test_abort();
        test_resp_stall_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
